// File: rtl/vpe_pkg.sv
// Shared VPE types: default result/tag widths and the tagged result record.
package vpe_pkg;

  localparam int VPE_DATA_W = 256;
  localparam int VPE_ADDR_W = 12;

  typedef struct packed {
    logic [VPE_ADDR_W-1:0] addr;
    logic [VPE_DATA_W-1:0] data;
  } vpe_res_t;

endpackage

// File: rtl/vpe_result_collector_if.sv
// Issue, result and deparser signals of the VPE result collector.
// Optional perf counters appear when VPE_RESULT_COLLECTOR_PERF_EN is defined.
interface vpe_result_collector_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 4
);
  logic [ADDR_W-1:0] i_issue_addr;
  logic              i_issue_v;
  logic              o_issue_rdy;
  logic [DATA_W-1:0] i_res;
  logic              i_res_v;
  logic              i_res_last;
  logic [DATA_W-1:0] o_inf_res;
  logic [ADDR_W-1:0] o_inf_res_addr;
  logic              o_inf_res_v;
  logic              i_inf_res_rdy;
  logic [CNT_W-1:0]  o_inflight;
  logic              o_err_orphan;
`ifdef VPE_RESULT_COLLECTOR_PERF_EN
  logic [31:0]       o_perf_res_cnt;
  logic [31:0]       o_perf_stall_cnt;

  modport master (
    output i_issue_addr, i_issue_v, i_res, i_res_v, i_res_last, i_inf_res_rdy,
    input  o_issue_rdy, o_inf_res, o_inf_res_addr, o_inf_res_v, o_inflight, o_err_orphan,
           o_perf_res_cnt, o_perf_stall_cnt
  );
  modport slave (
    input  i_issue_addr, i_issue_v, i_res, i_res_v, i_res_last, i_inf_res_rdy,
    output o_issue_rdy, o_inf_res, o_inf_res_addr, o_inf_res_v, o_inflight, o_err_orphan,
           o_perf_res_cnt, o_perf_stall_cnt
  );
`else
  modport master (
    output i_issue_addr, i_issue_v, i_res, i_res_v, i_res_last, i_inf_res_rdy,
    input  o_issue_rdy, o_inf_res, o_inf_res_addr, o_inf_res_v, o_inflight, o_err_orphan
  );
  modport slave (
    input  i_issue_addr, i_issue_v, i_res, i_res_v, i_res_last, i_inf_res_rdy,
    output o_issue_rdy, o_inf_res, o_inf_res_addr, o_inf_res_v, o_inflight, o_err_orphan
  );
`endif
endinterface

// File: rtl/vpe_sync_fifo.sv
// Synchronous FIFO, first-word-fall-through with a registered head and
// an occupancy count. DEPTH must be a power of 2.
module vpe_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] count_next;
  logic             do_push, do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
  assign rd_next = rd_ptr + 1'b1;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  // NOTE: storage is not reset; count/valid qualify its contents, and leaving it out keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      count <= count_next;
      valid <= (count_next != '0);
      // Head takes din when it becomes the only entry, else the next stored entry on pop.
      if (do_push && (count == '0 || (count == CNT_W'(1) && do_pop))) dout <= din;
      else if (do_pop && count > CNT_W'(1))                           dout <= mem[rd_next];
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert (!(push && !do_push)) else $error("vpe_sync_fifo: push while full");
  end
`endif

endmodule

// File: rtl/vpe_result_collector.sv
// VPE output stage: tags each final-layer result with its feature address,
// buffers it for the deparser and gates issue by credit. Optional perf counters:
// VPE_RESULT_COLLECTOR_PERF_EN.
module vpe_result_collector
  import vpe_pkg::*;
#(
  parameter int DATA_W    = VPE_DATA_W,
  parameter int ADDR_W    = VPE_ADDR_W,
  parameter int RES_DEPTH = 4,
  parameter int TAG_DEPTH = 8,
  parameter int CNT_W     = $clog2(TAG_DEPTH) + 1
) (
  input logic                   clk,
  input logic                   rst,
  vpe_result_collector_if.slave bus
);
  localparam int RC_W = $clog2(RES_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ADDR_W-1:0] tag_head;
  logic              tag_valid;
  logic [CNT_W-1:0]  tag_count;
  logic [RC_W-1:0]   res_count;
  logic [CNT_W:0]    credit_sum;
  logic              issue_rdy, issue_fire, res_fire, tag_pop, res_pop, res_valid;
  logic              err_orphan;
  entry_t            res_in, res_head;

  // Every in-flight inference owns one tag entry, so the tag count is the in-flight count.
  assign credit_sum = {1'b0, tag_count} + (CNT_W+1)'(res_count);
  assign issue_rdy  = ~rst & (credit_sum < (CNT_W+1)'(RES_DEPTH))
                           & (tag_count < CNT_W'(TAG_DEPTH));
  assign issue_fire = bus.i_issue_v & issue_rdy;
  assign res_fire   = bus.i_res_v & bus.i_res_last;
  assign tag_pop    = res_fire & tag_valid;
  assign res_pop    = res_valid & bus.i_inf_res_rdy;
  assign res_in     = '{addr: tag_head, data: bus.i_res};

  vpe_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(TAG_DEPTH), .CNT_W(CNT_W)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue_fire),
    .din   (bus.i_issue_addr),
    .pop   (tag_pop),
    .dout  (tag_head),
    .valid (tag_valid),
    .count (tag_count)
  );

  vpe_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(RES_DEPTH), .CNT_W(RC_W)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_pop),
    .din   (res_in),
    .pop   (res_pop),
    .dout  (res_head),
    .valid (res_valid),
    .count (res_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err_orphan <= 1'b0;
    else if (res_fire & ~tag_valid) err_orphan <= 1'b1;
  end

  assign bus.o_issue_rdy    = issue_rdy;
  assign bus.o_inf_res      = res_head.data;
  assign bus.o_inf_res_addr = res_head.addr;
  assign bus.o_inf_res_v    = res_valid;
  assign bus.o_inflight     = tag_count;
  assign bus.o_err_orphan   = err_orphan;

`ifdef VPE_RESULT_COLLECTOR_PERF_EN
  logic [31:0] perf_res_cnt, perf_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_res_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (res_pop && perf_res_cnt != '1) perf_res_cnt <= perf_res_cnt + 1'b1;
      if (res_valid && !bus.i_inf_res_rdy && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end

  assign bus.o_perf_res_cnt   = perf_res_cnt;
  assign bus.o_perf_stall_cnt = perf_stall_cnt;
`endif

endmodule

// File: tb/tb_vpe_result_collector.sv
// Directed self-checking bench for vpe_result_collector (default parameters).
module tb_vpe_result_collector;
  import vpe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  vpe_result_collector_if #(.DATA_W(256), .ADDR_W(12), .CNT_W(4)) bus ();

  vpe_result_collector #(
    .DATA_W(256), .ADDR_W(12), .RES_DEPTH(4), .TAG_DEPTH(8), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input vpe_res_t e);
    check({tag, ".v"},    bus.o_inf_res_v, 1'b1);
    check({tag, ".addr"}, bus.o_inf_res_addr, e.addr);
    check({tag, ".data"}, bus.o_inf_res, e.data);
  endtask

  function automatic logic [255:0] mk(input int k);
    return {8{32'(k) ^ 32'h5A5A_0000}};
  endfunction

  task automatic idle();
    bus.i_issue_v  = 1'b0;
    bus.i_res_v    = 1'b0;
    bus.i_res_last = 1'b0;
  endtask

  // Two issues, two final results, deparser always ready.
  task automatic run_basic(input string p);
    bus.i_inf_res_rdy = 1'b1;
    bus.i_issue_v = 1'b1; bus.i_issue_addr = 12'h010; cyc();
    bus.i_issue_addr = 12'h011; cyc();
    idle();
    check({p, ".inflight2"}, bus.o_inflight, 4'd2);
    cyc();
    bus.i_res_v = 1'b1; bus.i_res_last = 1'b1; bus.i_res = mk(32'hA); cyc();
    check({p, ".inflight1"}, bus.o_inflight, 4'd1);
    check_head({p, ".headA"}, '{addr: 12'h010, data: mk(32'hA)});
    bus.i_res = mk(32'hB); cyc();
    idle();
    check_head({p, ".headB"}, '{addr: 12'h011, data: mk(32'hB)});
    check({p, ".inflight0"}, bus.o_inflight, 4'd0);
    cyc();
    check({p, ".drained"}, bus.o_inf_res_v, 1'b0);
  endtask

  initial begin
    idle();
    bus.i_issue_addr  = '0;
    bus.i_res         = '0;
    bus.i_inf_res_rdy = 1'b0;

    // Reset state
    cyc(); cyc();
    check("rst.v",        bus.o_inf_res_v, 1'b0);
    check("rst.rdy",      bus.o_issue_rdy, 1'b0);
    check("rst.inflight", bus.o_inflight, 4'd0);
    check("rst.orphan",   bus.o_err_orphan, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst.rdy", bus.o_issue_rdy, 1'b1);

    run_basic("basic");

    // Credit limit with the deparser stalled
    bus.i_inf_res_rdy = 1'b0;
    bus.i_issue_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_issue_addr = 12'(12'h100 + i);
      cyc();
    end
    check("credit.rdy_low", bus.o_issue_rdy, 1'b0);
    check("credit.inflight4", bus.o_inflight, 4'd4);
    bus.i_issue_addr = 12'h1FF; cyc();
    idle();
    check("credit.ignored", bus.o_inflight, 4'd4);
    bus.i_res_v = 1'b1; bus.i_res_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_res = mk(32'h10 + i);
      cyc();
    end
    idle();
    check("credit.rdy_full", bus.o_issue_rdy, 1'b0);
    check("credit.inflight0", bus.o_inflight, 4'd0);
    check_head("credit.head0", '{addr: 12'h100, data: mk(32'h10)});
    cyc();
    check_head("credit.hold", '{addr: 12'h100, data: mk(32'h10)});
    bus.i_inf_res_rdy = 1'b1; cyc();
    bus.i_inf_res_rdy = 1'b0;
    check("credit.rdy_back", bus.o_issue_rdy, 1'b1);
    check_head("credit.head1", '{addr: 12'h101, data: mk(32'h11)});
    bus.i_inf_res_rdy = 1'b1; cyc();
    check_head("credit.head2", '{addr: 12'h102, data: mk(32'h12)});
    cyc();
    check_head("credit.head3", '{addr: 12'h103, data: mk(32'h13)});
    cyc();
    check("credit.empty", bus.o_inf_res_v, 1'b0);

    // Intermediate layers are ignored
    bus.i_issue_v = 1'b1; bus.i_issue_addr = 12'h200; cyc();
    bus.i_issue_addr = 12'h201; cyc();
    idle();
    bus.i_res_v = 1'b1; bus.i_res_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_res = mk(32'h70 + i);
      cyc();
    end
    check("layers.no_out", bus.o_inf_res_v, 1'b0);
    check("layers.inflight", bus.o_inflight, 4'd2);
    bus.i_res_last = 1'b1; bus.i_res = mk(32'hE); cyc();
    idle();
    check_head("layers.oldest", '{addr: 12'h200, data: mk(32'hE)});
    check("layers.inflight1", bus.o_inflight, 4'd1);

    // Simultaneous issue and result at inflight = 2
    bus.i_issue_v = 1'b1; bus.i_issue_addr = 12'h202; cyc();
    check("simul.one_result", bus.o_inf_res_v, 1'b0);
    check("simul.inflight_pre", bus.o_inflight, 4'd2);
    bus.i_issue_addr = 12'h203;
    bus.i_res_v = 1'b1; bus.i_res_last = 1'b1; bus.i_res = mk(32'hF); cyc();
    bus.i_issue_v = 1'b0;
    check("simul.inflight_keep", bus.o_inflight, 4'd2);
    check_head("simul.tagF", '{addr: 12'h201, data: mk(32'hF)});
    bus.i_res = mk(32'h6); cyc();
    check_head("simul.tagG", '{addr: 12'h202, data: mk(32'h6)});
    bus.i_res = mk(32'h8); cyc();
    idle();
    check_head("simul.tagH", '{addr: 12'h203, data: mk(32'h8)});
    check("simul.inflight0", bus.o_inflight, 4'd0);
    cyc();
    check("simul.empty", bus.o_inf_res_v, 1'b0);

    // Orphan result
    bus.i_res_v = 1'b1; bus.i_res_last = 1'b1; bus.i_res = mk(32'h99); cyc();
    idle();
    check("orphan.no_out", bus.o_inf_res_v, 1'b0);
    check("orphan.flag", bus.o_err_orphan, 1'b1);
    cyc(); cyc(); cyc();
    check("orphan.sticky", bus.o_err_orphan, 1'b1);

    // Asynchronous reset with three results buffered
    bus.i_inf_res_rdy = 1'b0;
    bus.i_issue_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_issue_addr = 12'(12'h300 + i);
      cyc();
    end
    idle();
    bus.i_res_v = 1'b1; bus.i_res_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_res = mk(32'h30 + i);
      cyc();
    end
    idle();
    bus.i_issue_v = 1'b1; bus.i_issue_addr = 12'h303; cyc();
    idle();
    check("arst.pre_v", bus.o_inf_res_v, 1'b1);
    check("arst.pre_inflight", bus.o_inflight, 4'd1);
    #2 rst = 1'b1;
    #1;
    check("arst.v", bus.o_inf_res_v, 1'b0);
    check("arst.inflight", bus.o_inflight, 4'd0);
    check("arst.orphan", bus.o_err_orphan, 1'b0);
    check("arst.rdy", bus.o_issue_rdy, 1'b0);
    check("arst.addr", bus.o_inf_res_addr, 12'h000);
    cyc();
    rst = 1'b0;
    #1;
    check("arst.rdy_back", bus.o_issue_rdy, 1'b1);
    run_basic("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
